alu_rr_sequencer: RTL and testbench

Shares one single-cycle ALU datapath (8-bit A/B, 3-bit op, registered 16-bit result and done pulse) between NUM_REQ requesters. A round-robin arbiter accepts one request at a time and registers its operands. The block then pulses the ALU start, waits for the ALU done, and returns the result tagged with the requester ID. It sits between the requester ports and the ALU instance and is the only driver of the ALU start/op/A/B inputs.

---
 rtl/alu_seq_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/alu_rr_sequencer.sv | 154 +++++++++++++++
 tb/tb_alu_rr_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared constants and types for the round-robin ALU sequencer.
package alu_seq_pkg;

   localparam int OP_W  = 3;
   localparam int OPD_W = 8;
   localparam int RES_W = 16;

   localparam logic [OP_W-1:0] OP_NOP = 3'b000;
   localparam logic [OP_W-1:0] OP_ADD = 3'b001;
   localparam logic [OP_W-1:0] OP_AND = 3'b010;
   localparam logic [OP_W-1:0] OP_XOR = 3'b011;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first set request at or above ptr, wrapping.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_idx,
   output logic               any_req
);

   always_comb begin
      int   idx;
      logic found;
      // NOTE: every output gets a default before the search loop so no path leaves
      // a value unassigned; that is what keeps this block from inferring latches.
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(ptr) + k) % NUM_REQ;
         if (!found && req[idx]) begin
            found          = 1'b1;
            grant[idx]     = 1'b1;
            grant_idx      = ID_W'(idx);
         end
      end
      any_req = found;
   end

endmodule

// File: rtl/alu_rr_sequencer.sv
// Shares one ALU between NUM_REQ requesters: round-robin grant, start pulse,
// bounded wait for done, and an ID-tagged response.
module alu_rr_sequencer
   import alu_seq_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int ID_W        = 2,
   parameter int TIMEOUT_CYC = 8
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [NUM_REQ*OP_W-1:0] req_op,
   input  logic [NUM_REQ*OPD_W-1:0] req_a,
   input  logic [NUM_REQ*OPD_W-1:0] req_b,
   output logic [NUM_REQ-1:0]      req_ready,
   output logic                    rsp_valid,
   output logic [ID_W-1:0]         rsp_id,
   output logic [RES_W-1:0]        rsp_result,
   output logic                    rsp_err,
   output logic                    busy,
   output logic                    alu_start,
   output logic [OP_W-1:0]         alu_op,
   output logic [OPD_W-1:0]        alu_a,
   output logic [OPD_W-1:0]        alu_b,
   input  logic                    alu_done,
   input  logic [RES_W-1:0]        alu_result
);

   localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

   state_t             state;
   logic [ID_W-1:0]    rr_ptr;
   logic [CNT_W-1:0]   cnt;
   logic [OP_W-1:0]    lat_op;
   logic [OPD_W-1:0]   lat_a;
   logic [OPD_W-1:0]   lat_b;
   logic [ID_W-1:0]    lat_id;

   logic [NUM_REQ-1:0] grant_oh;
   logic [ID_W-1:0]    grant_idx;
   logic               any_req;
   logic [OP_W-1:0]    sel_op;
   logic [OPD_W-1:0]   sel_a;
   logic [OPD_W-1:0]   sel_b;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .req       (req_valid),
      .ptr       (rr_ptr),
      .grant     (grant_oh),
      .grant_idx (grant_idx),
      .any_req   (any_req)
   );

   always_comb begin
      sel_op = '0;
      sel_a  = '0;
      sel_b  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_oh[i]) begin
            sel_op = req_op[i*OP_W +: OP_W];
            sel_a  = req_a[i*OPD_W +: OPD_W];
            sel_b  = req_b[i*OPD_W +: OPD_W];
         end
      end
   end

   // NOTE: all state here uses non-blocking assignments so every register samples
   // the pre-edge values, independent of statement order inside the block.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         cnt        <= '0;
         lat_op     <= '0;
         lat_a      <= '0;
         lat_b      <= '0;
         lat_id     <= '0;
         req_ready  <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= '0;
         rsp_result <= '0;
         rsp_err    <= 1'b0;
         busy       <= 1'b0;
         alu_start  <= 1'b0;
         alu_op     <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
      end else begin
         req_ready <= '0;
         rsp_valid <= 1'b0;
         alu_start <= 1'b0;
         case (state)
            // RESP arbitrates like IDLE so a waiting requester is granted on the
            // cycle after the response, giving one ALU op every four cycles.
            IDLE, RESP: begin
               state <= IDLE;
               busy  <= 1'b0;
               if (any_req) begin
                  req_ready <= grant_oh;
                  lat_op    <= sel_op;
                  lat_a     <= sel_a;
                  lat_b     <= sel_b;
                  lat_id    <= grant_idx;
                  rr_ptr    <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                  state     <= ISSUE;
                  busy      <= 1'b1;
               end
            end
            ISSUE: begin
               if (lat_op == OP_NOP) begin
                  rsp_valid  <= 1'b1;
                  rsp_id     <= lat_id;
                  rsp_result <= '0;
                  rsp_err    <= 1'b0;
                  state      <= RESP;
               end else begin
                  alu_start <= 1'b1;
                  alu_op    <= lat_op;
                  alu_a     <= lat_a;
                  alu_b     <= lat_b;
                  cnt       <= '0;
                  state     <= WAIT;
               end
            end
            WAIT: begin
               // The cycle our start pulse is on the wire cannot carry its done.
               if (!alu_start) begin
                  if (alu_done) begin
                     rsp_valid  <= 1'b1;
                     rsp_id     <= lat_id;
                     rsp_result <= alu_result;
                     rsp_err    <= 1'b0;
                     state      <= RESP;
                  end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                     rsp_valid  <= 1'b1;
                     rsp_id     <= lat_id;
                     rsp_result <= '0;
                     rsp_err    <= 1'b1;
                     state      <= RESP;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Directed bench for alu_rr_sequencer with a behavioural single-cycle ALU.
module tb_alu_rr_sequencer;
   import alu_seq_pkg::*;

   logic        clk;
   logic        reset_n;
   logic [3:0]  req_valid;
   logic [11:0] req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [3:0]  req_ready;
   logic        rsp_valid;
   logic [1:0]  rsp_id;
   logic [15:0] rsp_result;
   logic        rsp_err;
   logic        busy;
   logic        alu_start;
   logic [2:0]  alu_op;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic        alu_done;
   logic [15:0] alu_result;

   logic suppress;
   logic inject;
   int   cyc;
   int   n_checks;
   int   n_fail;

   typedef struct {
      int          cyc;
      int          id;
      logic [15:0] res;
      logic        err;
   } ev_t;

   ev_t grant_q[$];
   ev_t rsp_q[$];
   int  start_q[$];

   typedef struct {
      int          id;
      logic [2:0]  op;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] exp_res;
      int          exp_lat;
      int          exp_starts;
   } vec_t;

   vec_t vecs[6];

   alu_rr_sequencer #(
      .NUM_REQ     (4),
      .ID_W        (2),
      .TIMEOUT_CYC (8)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_ready  (req_ready),
      .rsp_valid  (rsp_valid),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_err    (rsp_err),
      .busy       (busy),
      .alu_start  (alu_start),
      .alu_op     (alu_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_done   (alu_done),
      .alu_result (alu_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Single-cycle ALU: registered result and done one edge after start.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         alu_done   <= 1'b0;
         alu_result <= 16'h0000;
      end else begin
         alu_done <= (alu_start && !suppress) || inject;
         case (alu_op)
            OP_ADD:  alu_result <= 16'(alu_a) + 16'(alu_b);
            OP_AND:  alu_result <= {8'h00, alu_a & alu_b};
            OP_XOR:  alu_result <= {8'h00, alu_a ^ alu_b};
            default: alu_result <= 16'h0000;
         endcase
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 4; i++)
         if (req_ready[i]) grant_q.push_back('{cyc, i, 16'h0, 1'b0});
      if (rsp_valid) rsp_q.push_back('{cyc, int'(rsp_id), rsp_result, rsp_err});
      if (alu_start) start_q.push_back(cyc);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_ctl"}, 32'({req_ready, rsp_valid, rsp_id, rsp_err, busy, alu_start, alu_op}), 32'h0);
      check({tag, "_result"}, 32'(rsp_result), 32'h0);
      check({tag, "_alu_ab"}, 32'({alu_a, alu_b}), 32'h0);
   endtask

   task automatic wait_grant(input int n0, output ev_t e, output logic ok);
      e  = '{-100, -1, 16'h0, 1'b0};
      ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         #1;
         if (grant_q.size() > n0) begin
            e  = grant_q[n0];
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic wait_rsp(input int n0, output ev_t e, output logic ok);
      e  = '{-100, -1, 16'h0, 1'b0};
      ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         #1;
         if (rsp_q.size() > n0) begin
            e  = rsp_q[n0];
            ok = 1'b1;
            return;
         end
      end
   endtask

   // One requester raises a request, drops it on grant and scrambles its operands.
   task automatic run_one(input int id, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, output ev_t g, output ev_t r);
      int   ng;
      int   nr;
      logic ok;
      ng = grant_q.size();
      nr = rsp_q.size();
      req_op[3*id +: 3] = op;
      req_a[8*id +: 8]  = a;
      req_b[8*id +: 8]  = b;
      req_valid[id]     = 1'b1;
      wait_grant(ng, g, ok);
      check("grant_seen", 32'(ok), 32'h1);
      req_valid[id]     = 1'b0;
      req_a[8*id +: 8]  = ~a;
      req_b[8*id +: 8]  = ~b;
      wait_rsp(nr, r, ok);
      check("rsp_seen", 32'(ok), 32'h1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      ev_t         g;
      ev_t         r;
      ev_t         ge[5];
      logic        ok;
      int          ng;
      int          nr;
      int          ns;
      int          n_id1;
      logic [15:0] cont_exp[4];

      vecs[0] = '{0, OP_ADD, 8'hFF, 8'h01, 16'h0100, 3, 1};
      vecs[1] = '{1, OP_XOR, 8'hA5, 8'h0F, 16'h00AA, 3, 1};
      vecs[2] = '{2, OP_AND, 8'hF0, 8'h3C, 16'h0030, 3, 1};
      vecs[3] = '{3, OP_ADD, 8'h80, 8'h80, 16'h0100, 3, 1};
      vecs[4] = '{2, OP_NOP, 8'h12, 8'h34, 16'h0000, 1, 0};
      vecs[5] = '{1, 3'b101, 8'h55, 8'h66, 16'h0000, 3, 1};
      cont_exp = '{16'h0030, 16'h00AA, 16'h0030, 16'h0030};

      n_checks  = 0;
      n_fail    = 0;
      reset_n   = 1'b0;
      req_valid = '0;
      req_op    = '0;
      req_a     = '0;
      req_b     = '0;
      suppress  = 1'b0;
      inject    = 1'b0;
      #1;
      check_idle_outputs("reset");
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      #1;
      check_idle_outputs("post_reset");

      // All four requesters valid continuously, rr_ptr starting at 0.
      req_op    = {OP_AND, OP_AND, OP_XOR, OP_AND};
      req_a     = {8'hF0, 8'hF0, 8'hA5, 8'hF0};
      req_b     = {8'h3C, 8'h3C, 8'h0F, 8'h3C};
      ng        = grant_q.size();
      nr        = rsp_q.size();
      req_valid = 4'hF;
      for (int k = 0; k < 5; k++) begin
         wait_grant(ng + k, ge[k], ok);
         check("cont_grant_seen", 32'(ok), 32'h1);
      end
      req_valid = '0;
      for (int k = 0; k < 5; k++) begin
         wait_rsp(nr + k, r, ok);
         check("cont_gid", 32'(ge[k].id), 32'(k % 4));
         if (k > 0) check("cont_gap", 32'(ge[k].cyc - ge[k-1].cyc), 32'd4);
         check("cont_rid", 32'(r.id), 32'(k % 4));
         check("cont_res", 32'(r.res), 32'(cont_exp[k % 4]));
         check("cont_lat", 32'(r.cyc - ge[k].cyc), 32'd3);
      end

      // Table-driven single requests.
      foreach (vecs[v]) begin
         ns = start_q.size();
         run_one(vecs[v].id, vecs[v].op, vecs[v].a, vecs[v].b, g, r);
         check("vec_gid", 32'(g.id), 32'(vecs[v].id));
         check("vec_rid", 32'(r.id), 32'(vecs[v].id));
         check("vec_res", 32'(r.res), 32'(vecs[v].exp_res));
         check("vec_err", 32'(r.err), 32'h0);
         check("vec_lat", 32'(r.cyc - g.cyc), 32'(vecs[v].exp_lat));
         check("vec_starts", 32'(start_q.size() - ns), 32'(vecs[v].exp_starts));
         if (vecs[v].exp_starts == 1)
            check("vec_start_cyc", 32'((start_q.size() > ns) ? start_q[ns] - g.cyc : -1), 32'd1);
      end

      // Requester 1 withdraws before its grant while requester 3 waits, rr_ptr=1.
      run_one(0, OP_ADD, 8'h01, 8'h02, g, r);
      ng = grant_q.size();
      nr = rsp_q.size();
      req_op[2:0]   = OP_ADD;
      req_a[7:0]    = 8'h03;
      req_b[7:0]    = 8'h04;
      req_valid[0]  = 1'b1;
      wait_grant(ng, g, ok);
      check("drop_g0_id", 32'(g.id), 32'h0);
      req_valid[0]   = 1'b0;
      req_op[5:3]    = OP_XOR;
      req_a[15:8]    = 8'h11;
      req_b[15:8]    = 8'h22;
      req_op[11:9]   = OP_ADD;
      req_a[31:24]   = 8'h01;
      req_b[31:24]   = 8'h02;
      req_valid[1]   = 1'b1;
      req_valid[3]   = 1'b1;
      @(negedge clk);
      #1;
      req_valid[1] = 1'b0;
      wait_grant(ng + 1, g, ok);
      check("drop_g_id", 32'(g.id), 32'd3);
      req_valid[3] = 1'b0;
      wait_rsp(nr + 1, r, ok);
      check("drop_rsp_id", 32'(r.id), 32'd3);
      check("drop_rsp_res", 32'(r.res), 32'h0003);
      check("drop_first_res", 32'(rsp_q[nr].res), 32'h0007);
      repeat (8) @(negedge clk);
      n_id1 = 0;
      for (int k = nr; k < rsp_q.size(); k++) if (rsp_q[k].id == 1) n_id1++;
      check("drop_no_id1", 32'(n_id1), 32'h0);
      check("drop_grants", 32'(grant_q.size() - ng), 32'd2);

      // ALU never answers: timeout response, then normal operation resumes.
      suppress = 1'b1;
      run_one(2, OP_ADD, 8'h10, 8'h20, g, r);
      check("tmo_err", 32'(r.err), 32'h1);
      check("tmo_res", 32'(r.res), 32'h0);
      check("tmo_lat", 32'(r.cyc - g.cyc), 32'd10);
      suppress = 1'b0;
      run_one(3, OP_XOR, 8'hFF, 8'h0F, g, r);
      check("after_tmo_err", 32'(r.err), 32'h0);
      check("after_tmo_res", 32'(r.res), 32'h00F0);
      check("after_tmo_lat", 32'(r.cyc - g.cyc), 32'd3);
      repeat (2) @(negedge clk);
      #1;
      check("hold_valid", 32'(rsp_valid), 32'h0);
      check("hold_res", 32'(rsp_result), 32'h00F0);

      // Reset while in WAIT: request discarded, late done ignored, rr_ptr back at 0.
      suppress = 1'b1;
      ng = grant_q.size();
      req_op[8:6]   = OP_ADD;
      req_a[23:16]  = 8'h05;
      req_b[23:16]  = 8'h05;
      req_valid[2]  = 1'b1;
      wait_grant(ng, g, ok);
      check("rst_g_id", 32'(g.id), 32'd2);
      req_valid[2] = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_busy_before", 32'(busy), 32'h1);
      nr = rsp_q.size();
      reset_n = 1'b0;
      #1;
      check_idle_outputs("mid_reset");
      repeat (2) @(negedge clk);
      #1;
      reset_n = 1'b1;
      @(negedge clk);
      #1;
      inject = 1'b1;
      @(negedge clk);
      #1;
      inject   = 1'b0;
      suppress = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      check("late_done_no_rsp", 32'(rsp_q.size() - nr), 32'h0);
      check("late_done_idle", 32'(busy), 32'h0);

      ng = grant_q.size();
      req_op[5:3]   = OP_AND;
      req_a[15:8]   = 8'hF0;
      req_b[15:8]   = 8'h3C;
      req_op[11:9]  = OP_ADD;
      req_a[31:24]  = 8'h80;
      req_b[31:24]  = 8'h80;
      req_valid[1]  = 1'b1;
      req_valid[3]  = 1'b1;
      wait_grant(ng, g, ok);
      check("ptr_rst_first", 32'(g.id), 32'd1);
      req_valid[1] = 1'b0;
      wait_grant(ng + 1, g, ok);
      check("ptr_rst_second", 32'(g.id), 32'd3);
      req_valid[3] = 1'b0;
      wait_rsp(nr + 1, r, ok);
      check("ptr_rst_rid1", 32'(rsp_q[nr].id), 32'd1);
      check("ptr_rst_res1", 32'(rsp_q[nr].res), 32'h0030);
      check("ptr_rst_rid3", 32'(r.id), 32'd3);
      check("ptr_rst_res3", 32'(r.res), 32'h0100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
